// File: rtl/mac_share_sched_if.sv
// Request/response bundle between the two FMAC requesters, the shared MAC scheduler
// and the result consumer.
interface mac_share_sched_if #(
    parameter int ACC_W = 24
);
    logic             req0_valid;
    logic [7:0]       req0_x;
    logic [7:0]       req0_y;
    logic             req0_acc;
    logic             req0_ready;
    logic             req1_valid;
    logic [7:0]       req1_x;
    logic [7:0]       req1_y;
    logic             req1_acc;
    logic             req1_ready;
    logic             out_valid;
    logic             out_ready;
    logic             out_id;
    logic [ACC_W-1:0] out_data;
    logic             out_ovf;

    modport master (
        output req0_valid, req0_x, req0_y, req0_acc,
        output req1_valid, req1_x, req1_y, req1_acc,
        output out_ready,
        input  req0_ready, req1_ready,
        input  out_valid, out_id, out_data, out_ovf
    );

    modport slave (
        input  req0_valid, req0_x, req0_y, req0_acc,
        input  req1_valid, req1_x, req1_y, req1_acc,
        input  out_ready,
        output req0_ready, req1_ready,
        output out_valid, out_id, out_data, out_ovf
    );
endinterface

// File: rtl/mac_share_sched.sv
// Round-robin scheduler sharing one 8x8 radix-4 Booth multiplier between two
// requesters, each owning a signed wrapping accumulator.

module multiplier (
    input  logic signed [7:0]  x,
    input  logic signed [7:0]  y,
    output logic signed [15:0] multOut
);
    logic [8:0]         ybits;
    logic signed [15:0] xs;
    logic signed [15:0] pp;
    logic signed [15:0] sum;

    always_comb begin
        ybits = {y, 1'b0};
        xs    = 16'(x);
        pp    = '0;
        sum   = '0;
        for (int i = 0; i < 4; i++) begin
            case (ybits[2*i +: 3])
                3'b001, 3'b010: pp = xs;
                3'b011:         pp = xs <<< 1;
                3'b100:         pp = -(xs <<< 1);
                3'b101, 3'b110: pp = -xs;
                default:        pp = '0;
            endcase
            sum = sum + (pp <<< (2*i));
        end
        multOut = sum;
    end
endmodule

// state | meaning
// IDLE  | grant a requester; operands latched on the handshake edge
// MUL   | latched operands drive the multiplier, product registered
// ACC   | product (sign-extended) loaded or added into acc[id], response registered
// RESP  | out_valid high, response held until out_ready
module mac_share_sched #(
    parameter int ACC_W = 24
) (
    input  logic              clk,
    input  logic              rst,
    mac_share_sched_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, MUL, ACC, RESP} state_t;

    state_t             state, state_nx;
    logic               last_grant;
    logic               grant_id;
    logic               hs;
    logic signed [7:0]  x_q, y_q;
    logic               acc_q, id_q;
    logic signed [15:0] mult_out, prod_q;
    logic signed [ACC_W-1:0] acc0, acc1, base, p_ext, sum;
    logic               ovf;
    logic [ACC_W-1:0]   out_data_q;
    logic               out_id_q, out_ovf_q;

    multiplier u_mult (
        .x       (x_q),
        .y       (y_q),
        .multOut (mult_out)
    );

    // On contention the grant alternates away from the last winner.
    always_comb begin
        if (bus.req0_valid && bus.req1_valid) grant_id = ~last_grant;
        else                                  grant_id = ~bus.req0_valid;
    end

    assign bus.req0_ready = !rst && (state == IDLE) && bus.req0_valid && !grant_id;
    assign bus.req1_ready = !rst && (state == IDLE) && bus.req1_valid &&  grant_id;
    assign hs             = bus.req0_ready || bus.req1_ready;

    assign bus.out_valid = (state == RESP);
    assign bus.out_data  = out_data_q;
    assign bus.out_id    = out_id_q;
    assign bus.out_ovf   = out_ovf_q;

    always_comb begin
        base  = id_q ? acc1 : acc0;
        p_ext = ACC_W'(prod_q);
        sum   = acc_q ? (base + p_ext) : p_ext;
        ovf   = acc_q && (base[ACC_W-1] == p_ext[ACC_W-1]) && (sum[ACC_W-1] != base[ACC_W-1]);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (hs) state_nx = MUL;
            MUL:     state_nx = ACC;
            ACC:     state_nx = RESP;
            RESP:    if (bus.out_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_grant <= 1'b1;
            x_q        <= '0;
            y_q        <= '0;
            acc_q      <= 1'b0;
            id_q       <= 1'b0;
            prod_q     <= '0;
            acc0       <= '0;
            acc1       <= '0;
            out_data_q <= '0;
            out_id_q   <= 1'b0;
            out_ovf_q  <= 1'b0;
        end else begin
            case (state)
                IDLE: if (hs) begin
                    x_q        <= grant_id ? bus.req1_x   : bus.req0_x;
                    y_q        <= grant_id ? bus.req1_y   : bus.req0_y;
                    acc_q      <= grant_id ? bus.req1_acc : bus.req0_acc;
                    id_q       <= grant_id;
                    last_grant <= grant_id;
                end
                MUL: prod_q <= mult_out;
                ACC: begin
                    if (id_q) acc1 <= sum;
                    else      acc0 <= sum;
                    out_data_q <= sum;
                    out_id_q   <= id_q;
                    out_ovf_q  <= ovf;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_mac_share_sched.sv
// Directed bench for mac_share_sched: a per-cycle reference model of grants, latency
// and accumulator arithmetic, plus literal checks on recorded responses.
module tb_mac_share_sched;
    localparam int W = 24;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mac_share_sched_if #(.ACC_W(W))  bus();
    mac_share_sched_if #(.ACC_W(16)) bus16();

    mac_share_sched #(.ACC_W(W))  dut   (.clk(clk), .rst(rst), .bus(bus));
    mac_share_sched #(.ACC_W(16)) dut16 (.clk(clk), .rst(rst), .bus(bus16));

    int vectors = 0;
    int miscompares = 0;

    bit          busy_m = 0;
    int          cnt_m = 0;
    longint      acc_m[2];
    bit          last_m = 1;
    logic [W-1:0] exp_data;
    bit          exp_id, exp_ovf;

    logic [W-1:0] rdata_q[$];
    bit           rid_q[$];
    bit           rovf_q[$];
    bit           grant_q[$];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic timeout(input string nm);
        vectors++;
        miscompares++;
        $display("FAIL %s: wait bound expired at %0t", nm, $time);
    endtask

    // Reference model: grants, 3-cycle response latency, wrapping accumulators.
    always @(negedge clk) begin
        bit e0, e1, ev, id, a;
        longint p, tru, w, lo, hi;
        lo = -(64'sd1 <<< (W-1));
        hi = (64'sd1 <<< (W-1)) - 1;
        if (rst) begin
            busy_m = 0; cnt_m = 0; acc_m[0] = 0; acc_m[1] = 0; last_m = 1;
            chk("rst_ready0", bus.req0_ready, 0);
            chk("rst_ready1", bus.req1_ready, 0);
            chk("rst_out_valid", bus.out_valid, 0);
            chk("rst_out_data", bus.out_data, 0);
            chk("rst_out_id", bus.out_id, 0);
            chk("rst_out_ovf", bus.out_ovf, 0);
        end else begin
            e0 = 0; e1 = 0;
            if (!busy_m) begin
                if (bus.req0_valid && bus.req1_valid) begin
                    e0 = last_m; e1 = !last_m;
                end else begin
                    e0 = bus.req0_valid; e1 = bus.req1_valid;
                end
            end
            if (busy_m) cnt_m++;
            ev = busy_m && (cnt_m >= 3);
            chk("ready0", bus.req0_ready, e0);
            chk("ready1", bus.req1_ready, e1);
            chk("out_valid", bus.out_valid, ev);
            if (ev) begin
                chk("out_id", bus.out_id, exp_id);
                chk("out_data", bus.out_data, exp_data);
                chk("out_ovf", bus.out_ovf, exp_ovf);
                if (bus.out_ready) begin
                    busy_m = 0;
                    rdata_q.push_back(bus.out_data);
                    rid_q.push_back(bus.out_id);
                    rovf_q.push_back(bus.out_ovf);
                end
            end
            if (e0 || e1) begin
                id = e1;
                a  = id ? bus.req1_acc : bus.req0_acc;
                p  = id ? longint'($signed(bus.req1_x)) * longint'($signed(bus.req1_y))
                        : longint'($signed(bus.req0_x)) * longint'($signed(bus.req0_y));
                tru = a ? acc_m[id] + p : p;
                w = tru;
                if (w > hi) w -= (64'sd1 <<< W);
                if (w < lo) w += (64'sd1 <<< W);
                acc_m[id] = w;
                exp_data = w[W-1:0];
                exp_ovf  = a && (tru > hi || tru < lo);
                exp_id   = id;
                last_m   = id;
                busy_m   = 1;
                cnt_m    = 0;
                grant_q.push_back(id);
            end
        end
    end

    // Requester drops valid on the edge its operation is accepted.
    always @(posedge clk) if (bus.req0_valid && bus.req0_ready) begin #1 bus.req0_valid = 1'b0; end
    always @(posedge clk) if (bus.req1_valid && bus.req1_ready) begin #1 bus.req1_valid = 1'b0; end

    task automatic issue(input bit id, input logic [7:0] x, input logic [7:0] y, input bit a);
        int g = 0;
        @(posedge clk); #2;
        while ((id ? bus.req1_valid : bus.req0_valid) && g < 200) begin
            @(posedge clk); #2; g++;
        end
        if (g >= 200) timeout("issue");
        if (id) begin
            bus.req1_x = x; bus.req1_y = y; bus.req1_acc = a; bus.req1_valid = 1'b1;
        end else begin
            bus.req0_x = x; bus.req0_y = y; bus.req0_acc = a; bus.req0_valid = 1'b1;
        end
    endtask

    task automatic wait_idle(input string nm);
        int g = 0;
        do begin @(negedge clk); #1; g++; end
        while ((busy_m || bus.req0_valid || bus.req1_valid) && g < 300);
        if (g >= 300) timeout(nm);
    endtask

    task automatic clear_log();
        rdata_q.delete(); rid_q.delete(); rovf_q.delete(); grant_q.delete();
    endtask

    task automatic pulse_rst();
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); @(posedge clk); #1 rst = 1'b0;
    endtask

    task automatic op16(input logic [7:0] x, input logic [7:0] y, input bit a,
                        input logic [15:0] ed, input bit eo, input string nm);
        int g = 0;
        @(posedge clk); #1;
        bus16.req0_x = x; bus16.req0_y = y; bus16.req0_acc = a; bus16.req0_valid = 1'b1;
        do begin @(negedge clk); g++; end while (!bus16.req0_ready && g < 20);
        if (g >= 20) timeout({nm, "_grant"});
        @(posedge clk); #1 bus16.req0_valid = 1'b0;
        g = 0;
        do begin @(negedge clk); g++; end while (!bus16.out_valid && g < 20);
        if (g >= 20) timeout({nm, "_resp"});
        chk({nm, "_data"}, bus16.out_data, ed);
        chk({nm, "_ovf"}, bus16.out_ovf, eo);
        @(posedge clk); #1;
    endtask

    initial begin
        int g;
        bus.req0_valid = 0; bus.req0_x = 0; bus.req0_y = 0; bus.req0_acc = 0;
        bus.req1_valid = 0; bus.req1_x = 0; bus.req1_y = 0; bus.req1_acc = 0;
        bus.out_ready = 1;
        bus16.req0_valid = 0; bus16.req0_x = 0; bus16.req0_y = 0; bus16.req0_acc = 0;
        bus16.req1_valid = 0; bus16.req1_x = 0; bus16.req1_y = 0; bus16.req1_acc = 0;
        bus16.out_ready = 1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Contention straight after reset: grants 0,1,0,1.
        clear_log();
        fork
            begin issue(0, 8'h01, 8'h02, 1'b0); issue(0, 8'h03, 8'h04, 1'b1); end
            begin issue(1, 8'hFB, 8'h06, 1'b0); issue(1, 8'h07, 8'hF8, 1'b1); end
        join
        wait_idle("contention");
        chk("cont_ngrants", grant_q.size(), 4);
        chk("cont_nresp", rdata_q.size(), 4);
        if (grant_q.size() == 4 && rdata_q.size() == 4) begin
            chk("cont_g0", grant_q[0], 0); chk("cont_g1", grant_q[1], 1);
            chk("cont_g2", grant_q[2], 0); chk("cont_g3", grant_q[3], 1);
            chk("cont_id0", rid_q[0], 0);  chk("cont_id1", rid_q[1], 1);
            chk("cont_d0", rdata_q[0], 24'h000002); chk("cont_d1", rdata_q[1], 24'hFFFFE2);
            chk("cont_d2", rdata_q[2], 24'h00000E); chk("cont_d3", rdata_q[3], 24'hFFFFAA);
        end

        // Accumulate chain on requester 1 from a fresh reset; acc0 untouched.
        pulse_rst();
        clear_log();
        issue(1, 8'h7F, 8'h7F, 1'b0);
        issue(1, 8'h80, 8'h80, 1'b1);
        wait_idle("chain");
        issue(0, 8'h00, 8'h05, 1'b1);
        wait_idle("acc0_probe");
        chk("chain_nresp", rdata_q.size(), 3);
        if (rdata_q.size() == 3) begin
            chk("chain_d0", rdata_q[0], 24'd16129); chk("chain_id0", rid_q[0], 1);
            chk("chain_d1", rdata_q[1], 24'd32513); chk("chain_id1", rid_q[1], 1);
            chk("acc0_zero", rdata_q[2], 24'd0);
        end

        // Single load -3*5.
        clear_log();
        issue(0, 8'hFD, 8'h05, 1'b0);
        wait_idle("load");
        chk("load_nresp", rdata_q.size(), 1);
        if (rdata_q.size() == 1) begin
            chk("load_data", rdata_q[0], 24'hFFFFF1);
            chk("load_id", rid_q[0], 0);
            chk("load_ovf", rovf_q[0], 0);
        end

        // Backpressure with requester 1 waiting; product lower bound -128*127.
        clear_log();
        @(posedge clk); #1 bus.out_ready = 1'b0;
        issue(0, 8'h80, 8'h7F, 1'b0);
        issue(1, 8'h02, 8'h02, 1'b0);
        g = 0;
        do begin @(negedge clk); #1; g++; end while (!(busy_m && cnt_m >= 3) && g < 50);
        if (g >= 50) timeout("bp_reach_resp");
        repeat (5) @(negedge clk);
        @(posedge clk); #1 bus.out_ready = 1'b1;
        @(negedge clk); #1;
        chk("bp_valid_before_release_edge", bus.out_valid, 1);
        @(posedge clk); #1;
        chk("bp_valid_after_release_edge", bus.out_valid, 0);
        wait_idle("backpressure");
        chk("bp_nresp", rdata_q.size(), 2);
        if (rdata_q.size() == 2) begin
            chk("bp_d0", rdata_q[0], 24'hFFC080);
            chk("bp_d1", rdata_q[1], 24'd4);
            chk("bp_id1", rid_q[1], 1);
        end

        // Reset while in ACC of an accumulate onto 100.
        clear_log();
        issue(0, 8'h0A, 8'h0A, 1'b0);
        wait_idle("load100");
        issue(0, 8'h05, 8'h05, 1'b1);
        g = 0;
        do begin @(negedge clk); #1; g++; end while (!(busy_m && cnt_m == 2) && g < 50);
        if (g >= 50) timeout("reach_acc");
        rst = 1'b1;
        #1;
        chk("midrst_valid", bus.out_valid, 0);
        chk("midrst_data", bus.out_data, 0);
        chk("midrst_ovf", bus.out_ovf, 0);
        @(posedge clk); @(posedge clk); #1 rst = 1'b0;
        issue(0, 8'h02, 8'h03, 1'b1);
        wait_idle("after_rst");
        chk("midrst_nresp", rdata_q.size(), 2);
        if (rdata_q.size() == 2) begin
            chk("midrst_d0", rdata_q[0], 24'd100);
            chk("after_rst_d", rdata_q[1], 24'd6);
        end

        // 16-bit accumulator wrap with overflow flag.
        op16(8'h80, 8'h80, 1'b0, 16'h4000, 1'b0, "w16_load");
        op16(8'h80, 8'h80, 1'b1, 16'h8000, 1'b1, "w16_ovf");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end
endmodule
